// File: rtl/std_selector_pkg.sv
// Shared selector helpers: encoding kinds and the width a select/index bus needs.
package std_selector_pkg;

  typedef enum logic [0:0] {
    selector_kind_BINARY,
    selector_kind_ONEHOT
  } selector_kind;

  // Binary width never collapses to zero so a single-entry index is still a real bus.
  function automatic int calc_select_width(input int entries, input selector_kind kind);
    if (kind == selector_kind_ONEHOT) begin
      return (entries < 1) ? 1 : entries;
    end
    return (entries <= 1) ? 1 : $clog2(entries);
  endfunction

endpackage

// File: rtl/std_rr_mux_if.sv
// Merger bus: ENTRIES input streams plus the single merged output stream.
interface std_rr_mux_if
  import std_selector_pkg::*;
#(
  parameter int  ENTRIES     = 2,
  parameter type DATA_TYPE   = logic,
  parameter int  INDEX_WIDTH = calc_select_width(ENTRIES, selector_kind_BINARY)
) ();

  logic [ENTRIES-1:0]     i_valid;
  logic [ENTRIES-1:0]     o_ready;
  DATA_TYPE               i_data [ENTRIES];
  logic [ENTRIES-1:0]     i_last;
  logic                   o_valid;
  logic                   i_ready;
  DATA_TYPE               o_data;
  logic [INDEX_WIDTH-1:0] o_index;
  logic                   o_last;

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_index, o_last
  );

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_index, o_last
  );

endinterface

// File: rtl/std_rr_arbiter.sv
// Combinational round-robin arbiter: lowest request at or above i_ptr, else lowest overall.
module std_rr_arbiter
  import std_selector_pkg::*;
#(
  parameter int ENTRIES     = 2,
  parameter int INDEX_WIDTH = calc_select_width(ENTRIES, selector_kind_BINARY)
) (
  input  logic [ENTRIES-1:0]     i_request,
  input  logic [INDEX_WIDTH-1:0] i_ptr,
  output logic [ENTRIES-1:0]     o_grant_onehot,
  output logic [INDEX_WIDTH-1:0] o_grant_index
);

  logic [ENTRIES-1:0] w_masked;
  logic [ENTRIES-1:0] w_pick;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_masked[i] = i_request[i] && (INDEX_WIDTH'(i) >= i_ptr);
    end
    w_pick = (|w_masked) ? w_masked : i_request;

    o_grant_onehot = '0;
    o_grant_index  = '0;
    // Descending scan so the last hit is the lowest set bit.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        o_grant_onehot    = '0;
        o_grant_onehot[i] = 1'b1;
        o_grant_index     = INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/std_rr_mux.sv
// N-to-1 round-robin stream merger with registered output and optional packet lock.
module std_rr_mux
  import std_selector_pkg::*;
#(
  parameter int       WIDTH        = 1,
  parameter type      DATA_TYPE    = logic [WIDTH-1:0],
  parameter DATA_TYPE DEFAULT_DATA = DATA_TYPE'(0),
  parameter int       ENTRIES      = 2,
  parameter bit       LOCK         = 1'b0,
  parameter int       INDEX_WIDTH  = calc_select_width(ENTRIES, selector_kind_BINARY)
) (
  input logic         i_clk,
  input logic         i_rst,
  std_rr_mux_if.slave io_bus
);

  logic [INDEX_WIDTH-1:0] r_ptr;
  logic [INDEX_WIDTH-1:0] r_lock_idx;
  logic                   r_locked;
  logic                   r_valid;
  DATA_TYPE               r_data;
  logic [INDEX_WIDTH-1:0] r_index;
  logic                   r_last;

  logic [ENTRIES-1:0]     w_arb_onehot;
  logic [INDEX_WIDTH-1:0] w_arb_index;
  logic [INDEX_WIDTH-1:0] w_grant;
  logic [INDEX_WIDTH-1:0] w_ptr_next;
  logic [ENTRIES-1:0]     w_ready;
  logic                   w_load;
  logic                   w_xfer;
  logic                   w_grant_valid;
  logic                   w_grant_last;
  DATA_TYPE               w_grant_data;

  std_rr_arbiter #(
    .ENTRIES     (ENTRIES),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_arbiter (
    .i_request      (io_bus.i_valid),
    .i_ptr          (r_ptr),
    .o_grant_onehot (w_arb_onehot),
    .o_grant_index  (w_arb_index)
  );

  always_comb begin
    w_grant = r_locked ? r_lock_idx : w_arb_index;
    w_load  = !r_valid || io_bus.i_ready;

    // While locked, ready depends only on the lock owner, never on other valids.
    w_ready = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_locked) begin
        w_ready[i] = (INDEX_WIDTH'(i) == r_lock_idx);
      end else begin
        w_ready[i] = w_arb_onehot[i];
      end
    end
    if (!w_load || i_rst) begin
      w_ready = '0;
    end

    w_grant_valid = io_bus.i_valid[w_grant];
    w_grant_last  = io_bus.i_last[w_grant];
    w_grant_data  = io_bus.i_data[w_grant];
    w_xfer        = w_grant_valid && (|w_ready);

    // Explicit wrap compare keeps non-power-of-two ENTRIES off the unused codes.
    w_ptr_next = (w_grant == INDEX_WIDTH'(ENTRIES - 1)) ? '0 : w_grant + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_data     <= DEFAULT_DATA;
      r_index    <= '0;
      r_last     <= 1'b0;
      r_ptr      <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      if (w_load) begin
        r_valid <= w_xfer;
      end
      if (w_xfer) begin
        r_data  <= w_grant_data;
        r_index <= w_grant;
        r_last  <= w_grant_last;
        if (!LOCK || w_grant_last) begin
          r_ptr    <= w_ptr_next;
          r_locked <= 1'b0;
        end else begin
          r_locked   <= 1'b1;
          r_lock_idx <= w_grant;
        end
      end
    end
  end

  assign io_bus.o_ready = w_ready;
  assign io_bus.o_valid = r_valid;
  assign io_bus.o_data  = r_data;
  assign io_bus.o_index = r_index;
  assign io_bus.o_last  = r_last;

endmodule
